// File: rtl/uart_cmd_responder.sv
// Serial command endpoint: 8N1 receiver feeding a 3-byte packet assembler with
// inter-byte timeout, plus an independent 8N1 transmitter for 1-byte responses.
module uart_cmd_responder #(
  parameter int BAUD_DIV = 2604,
  parameter int IDLE_TMO = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        frm_err
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam int TW = $clog2(IDLE_TMO + 1);
  localparam logic [CW-1:0] BIT_END = CW'(BAUD_DIV);
  localparam logic [CW-1:0] HALF    = CW'(BAUD_DIV / 2);
  localparam logic [TW-1:0] TMO_END = TW'(IDLE_TMO);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_st_e;

  // ---------------- RX front end ----------------
  logic rx_s1, rx_s2, rx_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  logic rx_fall;
  assign rx_fall = rx_d & ~rx_s2;

  // ---------------- RX FSM ----------------
  uart_st_e      rx_st, rx_nxt;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_st <= S_IDLE;
    else     rx_st <= rx_nxt;
  end

  always_comb begin
    rx_nxt  = rx_st;
    rx_tick = 1'b0;
    case (rx_st)
      S_IDLE:  if (rx_fall) rx_nxt = S_START;
      S_START: if (rx_cnt == HALF) begin
                 rx_tick = 1'b1;
                 rx_nxt  = rx_s2 ? S_IDLE : S_DATA;  // high mid-start is a glitch
               end
      S_DATA:  if (rx_cnt == BIT_END) begin
                 rx_tick = 1'b1;
                 if (rx_bit == 3'd7) rx_nxt = S_STOP;
               end
      S_STOP:  if (rx_cnt == BIT_END) begin
                 rx_tick = 1'b1;
                 rx_nxt  = S_IDLE;
               end
      default: rx_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else begin
      if (rx_st == S_IDLE)   rx_cnt <= rx_fall ? CW'(1) : '0;
      else if (rx_tick)      rx_cnt <= (rx_nxt == S_IDLE) ? '0 : CW'(1);
      else                   rx_cnt <= rx_cnt + 1'b1;
      if (rx_st == S_START)  rx_bit <= '0;
      else if (rx_st == S_DATA && rx_tick) begin
        rx_bit <= rx_bit + 3'd1;
        rx_sh  <= {rx_s2, rx_sh[7:1]};
      end
    end
  end

  // ---------------- packet assembler + timeout ----------------
  logic       start_edge, byte_ok, byte_bad, pkt_done;
  logic [1:0] idx;
  logic [7:0] cmd_sh, hi_sh;
  logic [TW-1:0] tmo_cnt;

  assign start_edge = (rx_st == S_IDLE) && rx_fall;
  assign byte_ok    = (rx_st == S_STOP) && rx_tick && rx_s2;
  assign byte_bad   = (rx_st == S_STOP) && rx_tick && !rx_s2;
  assign pkt_done   = byte_ok && (idx == 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      cmd_sh  <= '0;
      hi_sh   <= '0;
      cmd     <= '0;
      data    <= '0;
      frm_err <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      if (byte_bad) frm_err <= 1'b1;
      if (byte_ok) begin
        case (idx)
          2'd0:    begin cmd_sh <= rx_sh; idx <= 2'd1; end
          2'd1:    begin hi_sh  <= rx_sh; idx <= 2'd2; end
          default: begin
            cmd  <= cmd_sh;
            data <= {hi_sh, rx_sh};
            idx  <= 2'd0;
          end
        endcase
      end else if (byte_bad || tmo_cnt == TMO_END) begin
        idx <= 2'd0;
      end
      // Only a partial packet waiting in IDLE is subject to the timeout.
      if (rx_st != S_IDLE || rx_fall || idx == 2'd0) tmo_cnt <= '0;
      else if (tmo_cnt != TMO_END)                    tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Completion beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                              cmd_rdy <= 1'b0;
    else if (pkt_done)                                    cmd_rdy <= 1'b1;
    else if (clr_cmd_rdy || (start_edge && idx == 2'd0))  cmd_rdy <= 1'b0;
  end

  // ---------------- TX FSM ----------------
  uart_st_e      tx_st, tx_nxt;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_sh;
  logic          tx_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_st <= S_IDLE;
    else     tx_st <= tx_nxt;
  end

  always_comb begin
    tx_nxt  = tx_st;
    tx_tick = (tx_st != S_IDLE) && (tx_cnt == BIT_END);
    case (tx_st)
      S_IDLE:  if (send_resp) tx_nxt = S_START;
      S_START: if (tx_tick) tx_nxt = S_DATA;
      S_DATA:  if (tx_tick && tx_bit == 3'd7) tx_nxt = S_STOP;
      S_STOP:  if (tx_tick) tx_nxt = S_IDLE;
      default: tx_nxt = S_IDLE;
    endcase
  end

  // TX is registered so each bit starts exactly on a BAUD_DIV boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      TX        <= 1'b1;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_sh     <= '0;
      resp_sent <= 1'b0;
    end else if (tx_st == S_IDLE) begin
      if (send_resp) begin
        tx_sh     <= resp;
        resp_sent <= 1'b0;
        TX        <= 1'b0;
        tx_cnt    <= CW'(1);
      end
    end else if (tx_tick) begin
      tx_cnt <= (tx_st == S_STOP) ? '0 : CW'(1);
      case (tx_st)
        S_START: begin
          TX     <= tx_sh[0];
          tx_sh  <= {1'b0, tx_sh[7:1]};
          tx_bit <= '0;
        end
        S_DATA: begin
          TX     <= (tx_bit == 3'd7) ? 1'b1 : tx_sh[0];
          tx_sh  <= {1'b0, tx_sh[7:1]};
          tx_bit <= tx_bit + 3'd1;
        end
        default: resp_sent <= 1'b1;
      endcase
    end else begin
      tx_cnt <= tx_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Bench for uart_cmd_responder: bit-level host driver, packet-level reference model.
module tb_uart_cmd_responder;
  localparam int B   = 16;
  localparam int TMO = 200;
  localparam int S   = B/2 + 9*B;   // edge-to-stop-sample distance

  logic clk = 1'b0;
  logic rst, RX, TX, cmd_rdy, clr_cmd_rdy, send_resp, resp_sent, frm_err;
  logic [7:0]  cmd, resp;
  logic [15:0] data;

  uart_cmd_responder #(.BAUD_DIV(B), .IDLE_TMO(TMO)) dut (
    .clk(clk), .rst(rst), .RX(RX), .TX(TX), .cmd(cmd), .data(data),
    .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .resp(resp),
    .send_resp(send_resp), .resp_sent(resp_sent), .frm_err(frm_err));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   rdy_rises = 0, rdy_rise_cyc = -1;
  logic rdy_prev = 1'b0;
  always @(negedge clk) begin
    if (cmd_rdy === 1'b1 && rdy_prev !== 1'b1) begin
      rdy_rises++;
      rdy_rise_cyc = cyc;
    end
    rdy_prev = cmd_rdy;
  end

  // Reference model: packet-level state of the endpoint.
  int          m_idx, m_rises = 0, last_start;
  logic [7:0]  m_cmd, m_shc, m_shh;
  logic [15:0] m_data;
  logic        m_rdy, m_frm;

  task automatic model_reset();
    m_idx = 0; m_cmd = 8'h00; m_data = 16'h0000; m_rdy = 1'b0; m_frm = 1'b0;
  endtask

  // Host sends one frame; optional clr pulse aligned with the stop sample.
  task automatic send_byte(input logic [7:0] b, input logic stop, input logic clr_at_done);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    if (m_idx == 0) m_rdy = 1'b0;
    last_start = cyc;
    for (int m = 0; m < 10*B; m++) begin
      RX = fr[m/B];
      clr_cmd_rdy = clr_at_done && (m == 2 + S);
      @(negedge clk);
    end
    RX = 1'b1; clr_cmd_rdy = 1'b0;
    repeat (4) @(negedge clk);
    if (!stop) begin
      m_frm = 1'b1; m_idx = 0;
    end else begin
      case (m_idx)
        0: m_shc = b;
        1: m_shh = b;
        default: begin m_cmd = m_shc; m_data = {m_shh, b}; m_rdy = 1'b1; m_rises++; end
      endcase
      m_idx = (m_idx + 1) % 3;
    end
  endtask

  task automatic send_pkt(input logic [7:0] c, input logic [15:0] d, input logic clr_at_done);
    send_byte(c, 1'b1, 1'b0);
    send_byte(d[15:8], 1'b1, 1'b0);
    send_byte(d[7:0], 1'b1, clr_at_done);
  endtask

  // Response frame checked at the first and last cycle of every bit.
  task automatic tx_frame(input logic [7:0] r, input logic inject);
    logic [9:0] fr;
    int c0;
    fr = {1'b1, r, 1'b0};
    resp = r; send_resp = 1'b1; c0 = cyc;
    @(negedge clk);
    send_resp = 1'b0; resp = ~r;
    for (int m = 1; m <= 10*B; m++) begin
      if ((m-1) % B == 0 || m % B == 0) begin
        checks++;
        if ({TX, resp_sent} !== {fr[(m-1)/B], 1'b0}) begin
          failures++;
          $display("FAIL tx_bit%0d cyc+%0d got TX=%b sent=%b exp TX=%b sent=0",
                   (m-1)/B, m, TX, resp_sent, fr[(m-1)/B]);
        end
      end
      send_resp = inject && (m == 3*B + 5);
      @(negedge clk);
    end
    send_resp = 1'b0;
    checks++;
    if ({TX, resp_sent} !== 2'b11) begin
      failures++;
      $display("FAIL tx_done got TX=%b sent=%b exp 1 1 (c0=%0d cyc=%0d)", TX, resp_sent, c0, cyc);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({TX, cmd, data, cmd_rdy, resp_sent, frm_err} !== {1'b1, 8'h00, 16'h0000, 3'b000}) begin
      failures++;
      $display("FAIL reset_in got TX=%b cmd=%h data=%h rdy=%b sent=%b ferr=%b", TX, cmd, data, cmd_rdy, resp_sent, frm_err);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({TX, cmd, data, cmd_rdy, resp_sent, frm_err} !== {1'b1, 8'h00, 16'h0000, 3'b000}) begin
      failures++;
      $display("FAIL reset_out got TX=%b cmd=%h data=%h rdy=%b sent=%b ferr=%b", TX, cmd, data, cmd_rdy, resp_sent, frm_err);
    end
  endtask

  task automatic test_basic();
    send_pkt(8'h05, 16'h00FF, 1'b0);
    checks++;
    if (rdy_rise_cyc !== last_start + 3 + S) begin
      failures++; $display("FAIL basic_rdy_time got=%0d exp=%0d", rdy_rise_cyc, last_start + 3 + S);
    end
    checks++;
    if ({cmd, data, cmd_rdy} !== {8'h05, 16'h00FF, 1'b1}) begin
      failures++; $display("FAIL basic_pkt got cmd=%h data=%h rdy=%b exp 05 00ff 1", cmd, data, cmd_rdy);
    end
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    m_rdy = 1'b0;
    checks++;
    if ({cmd, data, cmd_rdy} !== {8'h05, 16'h00FF, 1'b0}) begin
      failures++; $display("FAIL basic_clr got cmd=%h data=%h rdy=%b exp 05 00ff 0", cmd, data, cmd_rdy);
    end
  endtask

  task automatic test_response();
    tx_frame(8'hA5, 1'b1);
    tx_frame(8'($urandom), 1'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout();
    send_byte(8'h06, 1'b1, 1'b0);
    repeat (TMO + 10) @(negedge clk);
    m_idx = 0;
    send_pkt(8'h08, 16'h0000, 1'b0);
    checks++;
    if ({cmd, data, cmd_rdy} !== {m_cmd, m_data, m_rdy} || m_cmd !== 8'h08) begin
      failures++; $display("FAIL tmo_pkt got cmd=%h data=%h rdy=%b exp %h %h %b", cmd, data, cmd_rdy, m_cmd, m_data, m_rdy);
    end
    checks++;
    if (rdy_rises !== m_rises) begin
      failures++; $display("FAIL tmo_rises got=%0d exp=%0d", rdy_rises, m_rises);
    end
  endtask

  task automatic test_frm_err();
    send_byte(8'h33, 1'b1, 1'b0);
    send_byte(8'h44, 1'b0, 1'b0);
    checks++;
    if ({frm_err, cmd, data, cmd_rdy} !== {1'b1, m_cmd, m_data, m_rdy} || rdy_rises !== m_rises) begin
      failures++; $display("FAIL ferr_flag got ferr=%b cmd=%h rdy=%b rises=%0d exp 1 %h %b %0d", frm_err, cmd, cmd_rdy, rdy_rises, m_cmd, m_rdy, m_rises);
    end
    send_pkt(8'h02, 16'h1234, 1'b0);
    checks++;
    if ({frm_err, cmd, data, cmd_rdy} !== {1'b1, 8'h02, 16'h1234, 1'b1}) begin
      failures++; $display("FAIL ferr_next got ferr=%b cmd=%h data=%h rdy=%b exp 1 02 1234 1", frm_err, cmd, data, cmd_rdy);
    end
  endtask

  task automatic test_glitch_collision();
    // Glitch at packet start knocks down cmd_rdy but yields no byte.
    RX = 1'b0; repeat (B/4) @(negedge clk);
    RX = 1'b1; repeat (2*B) @(negedge clk);
    if (m_idx == 0) m_rdy = 1'b0;
    checks++;
    if ({cmd, data, cmd_rdy} !== {m_cmd, m_data, m_rdy}) begin
      failures++; $display("FAIL glitch0 got cmd=%h data=%h rdy=%b exp %h %h %b", cmd, data, cmd_rdy, m_cmd, m_data, m_rdy);
    end
    // Mid-packet glitch must leave the byte index where it was.
    send_byte(8'h11, 1'b1, 1'b0);
    RX = 1'b0; repeat (B/4) @(negedge clk);
    RX = 1'b1; repeat (2*B) @(negedge clk);
    send_byte(8'h22, 1'b1, 1'b0);
    send_byte(8'h33, 1'b1, 1'b1);
    checks++;
    if ({cmd, data, cmd_rdy} !== {8'h11, 16'h2233, 1'b1}) begin
      failures++; $display("FAIL glitch_collide got cmd=%h data=%h rdy=%b exp 11 2233 1", cmd, data, cmd_rdy);
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 5; p++) begin
      send_pkt(8'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      checks++;
      if ({cmd, data, cmd_rdy, frm_err} !== {m_cmd, m_data, m_rdy, m_frm}) begin
        failures++; $display("FAIL rand_pkt%0d got cmd=%h data=%h rdy=%b ferr=%b exp %h %h %b %b",
                             p, cmd, data, cmd_rdy, frm_err, m_cmd, m_data, m_rdy, m_frm);
      end
      if ($urandom_range(0, 1) == 1) begin
        clr_cmd_rdy = 1'b1; @(negedge clk); clr_cmd_rdy = 1'b0; m_rdy = 1'b0;
        checks++;
        if ({cmd, data, cmd_rdy} !== {m_cmd, m_data, 1'b0}) begin
          failures++; $display("FAIL rand_clr%0d got cmd=%h data=%h rdy=%b exp %h %h 0", p, cmd, data, cmd_rdy, m_cmd, m_data);
        end
      end
    end
    checks++;
    if (rdy_rises !== m_rises) begin
      failures++; $display("FAIL rand_rises got=%0d exp=%0d", rdy_rises, m_rises);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0]  fr;
    logic [15:0] d;
    fr = {1'b1, 8'($urandom), 1'b0};
    resp = 8'($urandom); send_resp = 1'b1;
    @(negedge clk);
    send_resp = 1'b0;
    for (int m = 0; m < 3*B + B/2; m++) begin
      RX = fr[m/B];
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({TX, cmd, data, cmd_rdy, resp_sent, frm_err} !== {1'b1, 8'h00, 16'h0000, 3'b000}) begin
      failures++; $display("FAIL reset_mid got TX=%b cmd=%h data=%h rdy=%b sent=%b ferr=%b", TX, cmd, data, cmd_rdy, resp_sent, frm_err);
    end
    RX = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    d = 16'($urandom);
    send_pkt(8'h3C, d, 1'b0);
    checks++;
    if ({TX, cmd, data, cmd_rdy, frm_err} !== {1'b1, 8'h3C, d, 1'b1, 1'b0}) begin
      failures++; $display("FAIL reset_next got TX=%b cmd=%h data=%h rdy=%b ferr=%b exp 1 3c %h 1 0", TX, cmd, data, cmd_rdy, frm_err, d);
    end
  endtask

  initial begin
    rst = 1'b1; RX = 1'b1; clr_cmd_rdy = 1'b0; send_resp = 1'b0; resp = 8'h00;
    model_reset();
    test_reset();
    test_basic();
    test_response();
    test_timeout();
    test_frm_err();
    test_glitch_collision();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
